// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Brief    : Four-way round-robin arbiter driving the shared 4:1 mux select.
//            Optional hold limit enabled by macro MUX4_ARB_HOLD_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o,
  output logic [1:0] sel_o,
  output logic       busy_o
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  logic [1:0] r_last_owner;
  logic       w_winner_found;
  logic [1:0] w_winner;
  logic [1:0] w_idx;

  generate
    if (HOLD_MAX < 2 || HOLD_MAX > 256) begin : g_hold_max_check
      $error("mux4_rr_arbiter: HOLD_MAX out of range 2..256");
    end
  endgenerate

  // In GRANT the owner equals r_last_owner, so one search from
  // r_last_owner+1 serves both the idle pick and the handover pick.
  always_comb begin
    w_winner_found = 1'b0;
    w_winner       = 2'd0;
    w_idx          = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_last_owner + 2'(i + 1);
      if (!w_winner_found && req_i[w_idx]) begin
        w_winner_found = 1'b1;
        w_winner       = w_idx;
      end
    end
  end

`ifdef MUX4_ARB_HOLD_LIMIT_EN
  localparam int               CW          = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0]    C_HOLD_LAST = CW'(HOLD_MAX - 1);
  logic [CW-1:0] r_hold_cnt;
  logic          w_contend;

  assign w_contend = |(req_i & ~gnt_o);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_last_owner <= 2'd3;
      gnt_o        <= 4'b0000;
      sel_o        <= 2'd0;
      busy_o       <= 1'b0;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
      r_hold_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_winner_found) begin
            r_state      <= S_GRANT;
            r_last_owner <= w_winner;
            gnt_o        <= 4'b0001 << w_winner;
            sel_o        <= w_winner;
            busy_o       <= 1'b1;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
            r_hold_cnt   <= '0;
`endif
          end
        end
        S_GRANT: begin
          if (!req_i[r_last_owner]) begin
            if (w_winner_found) begin
              r_last_owner <= w_winner;
              gnt_o        <= 4'b0001 << w_winner;
              sel_o        <= w_winner;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
              r_hold_cnt   <= '0;
`endif
            end else begin
              r_state <= S_IDLE;
              gnt_o   <= 4'b0000;
              busy_o  <= 1'b0;
            end
          end
`ifdef MUX4_ARB_HOLD_LIMIT_EN
          // Owner still requesting: rotate only once the hold budget is spent.
          else if (r_hold_cnt == C_HOLD_LAST && w_contend) begin
            r_last_owner <= w_winner;
            gnt_o        <= 4'b0001 << w_winner;
            sel_o        <= w_winner;
            r_hold_cnt   <= '0;
          end else if (r_hold_cnt != C_HOLD_LAST) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
`endif
        end
        default: begin
          r_state <= S_IDLE;
          gnt_o   <= 4'b0000;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Brief    : Scoreboard bench for mux4_rr_arbiter with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

  localparam int HOLD_MAX = 4;

  logic       clk;
  logic       rst_ni;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  // Reference state: owner < 0 means nobody holds the grant.
  int m_owner = -1;
  int m_last  = 3;
  int m_sel   = 0;
  int m_cnt   = 0;

  mux4_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .req_i (req),
    .gnt_o (gnt),
    .sel_o (sel),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_grant(input int w);
    m_owner = w;
    m_last  = w;
    m_sel   = w;
    m_cnt   = 0;
  endfunction

  function automatic void model_step(input logic rst_n_s, input logic [3:0] r);
    int win;
    int idx;
    if (!rst_n_s) begin
      m_owner = -1;
      m_last  = 3;
      m_sel   = 0;
      m_cnt   = 0;
      return;
    end
    win = -1;
    for (int i = 1; i <= 4; i++) begin
      idx = (m_last + i) % 4;
      if (win < 0 && r[idx]) win = idx;
    end
    if (m_owner < 0) begin
      if (win >= 0) model_grant(win);
    end else if (!r[m_owner]) begin
      if (win >= 0) model_grant(win);
      else m_owner = -1;
    end else begin
`ifdef MUX4_ARB_HOLD_LIMIT_EN
      if (m_cnt == HOLD_MAX - 1 && (r & ~(4'b0001 << m_owner)) != 4'b0000)
        model_grant(win);
      else if (m_cnt < HOLD_MAX - 1)
        m_cnt = m_cnt + 1;
`endif
    end
  endfunction

  // Apply inputs, let the DUT sample them on the next rising edge, and
  // record the state the model says that edge produces.
  task automatic drive(input logic rst_v, input logic [3:0] r);
    exp_t e;
    rst_ni = rst_v;
    req    = r;
    @(posedge clk);
    model_step(rst_v, r);
    e.g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    e.s = 2'(m_sel);
    e.b = (m_owner >= 0);
    exp_q.push_back(e);
    #1;
  endtask

  function automatic logic [3:0] model_gnt();
    return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
  endfunction

  // Monitor: outputs are presented every cycle; check them mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e.g) begin
        errors++;
        $display("FAIL gnt at %0t: got %b expected %b", $time, gnt, e.g);
      end
      checks++;
      if (sel !== e.s) begin
        errors++;
        $display("FAIL sel at %0t: got %0d expected %0d", $time, sel, e.s);
      end
      checks++;
      if (busy !== e.b) begin
        errors++;
        $display("FAIL busy at %0t: got %b expected %b", $time, busy, e.b);
      end
    end
  end

  initial begin
    logic [3:0] r;
    rst_ni = 1'b0;
    req    = 4'b0000;

    // Reset, then first grant from all-request.
    drive(1'b0, 4'b1111);
    drive(1'b0, 4'b0000);
    drive(1'b1, 4'b1111);

    // Rotation on release: owner drops its own request for one cycle.
    for (int i = 0; i < 5; i++) drive(1'b1, 4'b1111 & ~model_gnt());

    // Idle and resume: reach owner 2, release with no others, then 1001.
    drive(1'b1, 4'b0000);
    drive(1'b1, 4'b0100);
    drive(1'b1, 4'b0100);
    drive(1'b1, 4'b0000);
    drive(1'b1, 4'b0000);
    drive(1'b1, 4'b1001);
    drive(1'b1, 4'b1001);

    // Hold limit / hold forever: requester 0 held, requester 1 joins.
    drive(1'b1, 4'b0000);
    drive(1'b1, 4'b0001);
    for (int i = 0; i < 8; i++) drive(1'b1, 4'b0011);

    // Single requester without contention for 20 cycles.
    drive(1'b1, 4'b0000);
    for (int i = 0; i < 20; i++) drive(1'b1, 4'b0100);

    // Reset mid-grant with owner 3, then re-request.
    drive(1'b1, 4'b0000);
    drive(1'b1, 4'b1000);
    drive(1'b1, 4'b1000);
    drive(1'b0, 4'b1000);
    drive(1'b1, 4'b1000);
    drive(1'b1, 4'b1000);

    // Randomized traffic with occasional sticky requests and resets.
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 99) != 0), r);
    end

    drive(1'b1, 4'b0000);
    @(negedge clk);
    #1;
    done = 1;
  end

  initial begin
    fork
      wait (done);
      begin
        #500000;
        errors++;
        $display("FAIL timeout: stimulus did not complete");
      end
    join_any
    disable fork;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares the 4:1 one-bit mux datapath between four requesters. It grants at most one requester at a time and drives the mux select with the owner's index. Each grant is held for as long as the owner keeps requesting, with an optional hold limit that forces rotation. The block sits directly in front of the `mux4to1` select input in the shared-line datapath.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive cycles one owner may hold the grant while others wait. Legal range 2..256. Used only when `MUX4_ARB_HOLD_LIMIT_EN` is defined.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `req_i`  in  4  request per requester; bit k corresponds to mux input k (a=0, b=1, c=2, d=3).
- `gnt_o`  out  4  one-hot registered grant; all zeros when no owner.
- `sel_o`  out  2  binary index of the current owner; connects to the mux `sel_i`.
- `busy_o`  out  1  high while any grant is active (`|gnt_o`).

## Operation
- State machine has two states:
  - IDLE: no owner.
  - GRANT: owner k holds the grant.
- Search order starts at `start = (last_owner + 1) mod 4` and proceeds start, start+1, start+2, start+3 (mod 4). The first set `req_i` bit in that order wins.
- IDLE:
  - Any `req_i` set → GRANT with the winner.
  - No request → stay in IDLE.
- GRANT, owner k, `req_i[k]` = 0 (release):
  - Search the current `req_i` from k+1.
  - Winner found → GRANT with the new owner, with no idle gap.
  - No winner → IDLE.
- GRANT, owner k, `req_i[k]` = 1: the owner keeps the grant, except for forced rotation (see Configuration).
- On every new grant, `last_owner` is set to the winner.
- `sel_o` follows the owner on every grant. In IDLE it holds its last value.
- `gnt_o` is always one-hot or zero. Requests from non-owners never disturb the current owner.
- A request dropped before it is granted is simply lost. Requests are not latched.

## Timing
- All outputs are registered.
- Latency from request to grant is 1 cycle: `req_i` sampled high at edge N gives `gnt_o` at N+1, with `busy_o` and `sel_o` valid on the same edge.
- Release latency is 1 cycle: owner drops `req_i` at edge N, and `gnt_o[k]` clears at N+1. The next owner's grant appears on that same N+1 edge.
- Reset values: `gnt_o` = 0, `sel_o` = 0, `busy_o` = 0, state = IDLE, `last_owner` = 3 (so the first search starts at requester 0), hold counter = 0.
- `rst_ni` low at any edge, including mid-grant, returns all of the above to reset values on that edge. Requests are ignored while `rst_ni` is low.
- Simultaneous requests: the winner is chosen strictly by search order. For example, with `last_owner` = 1 and `req_i` = 4'b1011, requester 3 wins.

## Configuration
- Macro: `MUX4_ARB_HOLD_LIMIT_EN`.
- When defined, a hold counter is compiled in:
  - Reset to 0 on each new grant.
  - Increments each GRANT cycle, saturating at `HOLD_MAX-1`.
  - Forced rotation: if the counter equals `HOLD_MAX-1` and any other requester is active, the grant moves to the winner of the search from k+1 on the next edge, even though `req_i[k]` = 1.
  - Net effect: the owner holds exactly `HOLD_MAX` cycles under contention.
  - With no contention, the owner keeps the grant indefinitely and the counter stays saturated.
- When not defined:
  - No counter logic exists.
  - The owner keeps the grant until it deasserts `req_i[k]`.
  - `HOLD_MAX` is ignored.

## Test plan
- **Reset / first grant:** after reset, `req_i` = 4'b1111 at edge 1 → `gnt_o` = 4'b0001, `sel_o` = 0, `busy_o` = 1 at edge 2. All outputs are 0 during reset.
- **Rotation on release:** with `req_i` = 4'b1111, each owner drops its request for one cycle after being granted → grants go 0,1,2,3,0 with no idle cycles between them, and `sel_o` tracks 0,1,2,3,0.
- **Idle and resume:** owner 2 releases with no other requests → IDLE (`gnt_o` = 0, `sel_o` stays 2). A later `req_i` = 4'b1001 → requester 3 is granted, since the search starts at 3.
- **Hold limit (macro defined, `HOLD_MAX` = 4):** requester 0 is held from cycle N while requester 1 requests from N+1 → `gnt_o` = 4'b0001 for cycles N..N+3, then 4'b0010 at N+4. Without the macro, requester 0 holds indefinitely.
- **Hold without contention (macro defined):** a single requester is held for 20 cycles → grant is never dropped.
- **Reset mid-grant:** owner 3 is active and `rst_ni` is low for one edge → `gnt_o` = 0 and `sel_o` = 0 on that edge. After reset releases, `req_i` = 4'b1000 → requester 3 is granted 1 cycle later.
